// File: rtl/key_direction_queue_pkg.sv
// Shared definitions for the maze-game key input stage and the player controller.
// Direction codes map key index i directly to direction code i.
package key_direction_queue_pkg;

  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    DIR_POS_X = 2'd0,
    DIR_POS_Y = 2'd1,
    DIR_NEG_X = 2'd2,
    DIR_NEG_Y = 2'd3
  } dir_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } push_req_t;

  // Lowest-index set bit wins, so KEY0 has priority when presses coincide.
  function automatic push_req_t pick_pending(input logic [NUM_KEYS-1:0] pend);
    push_req_t r;
    r.hit = 1'b0;
    r.dir = DIR_POS_X;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        r.hit = 1'b1;
        r.dir = dir_t'(2'(i));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_direction_queue_debouncer.sv
// One key: two-flop synchroniser, inversion to active-high, and a stability
// counter that only lets a level change through after a sustained difference.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             sample;

  assign sample = sync[1];

  // The counter runs while the synced sample disagrees with the accepted level;
  // acceptance lands DEBOUNCE_CYCLES+2 edges after a clean key change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], ~key_n};
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_direction_queue.sv
// Debounced key presses become direction requests queued in a small FIFO,
// drained by the player-movement controller with a valid/ack handshake.
module key_direction_queue
  import key_direction_queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       flush,
  input  logic       dir_ack,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic [3:0] keys_held,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_KEYS-1:0] held_q;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pend_clr;
  dir_t                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    tail_ptr;
  logic [CNT_W-1:0]    count;
  push_req_t           req;
  logic                pop;
  logic                full;
  logic                dup;
  logic                do_push;
  logic                drop_full;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n[i]),
      .level(keys_held[i])
    );
  end

  assign press    = keys_held & ~held_q;
  assign req      = pick_pending(pending);
  assign pend_clr = req.hit ? (NUM_KEYS'(1) << req.dir) : '0;

  assign dir_valid = (count != '0);
  assign dir       = mem[rd_ptr];
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign tail_ptr  = wr_ptr - PTR_W'(1);
  assign pop       = dir_valid & dir_ack;

  // A request matching the newest queued entry adds nothing for the mover.
  assign dup       = dir_valid && (req.dir == mem[tail_ptr]);
  assign do_push   = req.hit && !dup && (!full || pop);
  assign drop_full = req.hit && !dup && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q   <= '0;
      pending  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= DIR_POS_X;
    end else begin
      held_q <= keys_held;
      if (flush) begin
        pending <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
      end else begin
        pending <= (pending & ~pend_clr) | press;
        if (do_push) begin
          mem[wr_ptr] <= req.dir;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(do_push) - CNT_W'(pop);
        if (drop_full) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_direction_queue.sv
// Bench for key_direction_queue: directed scenarios plus a randomized run,
// checked against a queue-based reference model advanced once per clock.
module tb_key_direction_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       flush;
  logic       dir_ack;
  logic       dir_valid;
  logic [1:0] dir;
  logic [3:0] keys_held;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] m_s1, m_s2, m_lvl, m_lprev, m_pend;
  logic [D:0] hwin [4];
  int         hcnt [4];
  int         m_q[$];
  logic       m_ovf;

  key_direction_queue #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .flush    (flush),
    .dir_ack  (dir_ack),
    .dir_valid(dir_valid),
    .dir      (dir),
    .keys_held(keys_held),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // A level flips once the last D+1 synced samples all disagree with it.
  task automatic model_edge();
    logic [3:0] rose, nlvl, newp;
    int idx;
    bit pop, push, dup;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lprev = '0; m_pend = '0; m_ovf = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin hwin[i] = '0; hcnt[i] = 0; end
      return;
    end
    rose = m_lvl & ~m_lprev;
    nlvl = m_lvl;
    for (int i = 0; i < 4; i++) begin
      hwin[i] = {hwin[i][D-1:0], m_s2[i]};
      if (hcnt[i] < D + 1) hcnt[i]++;
      if (hcnt[i] == D + 1 && hwin[i] == {(D+1){~m_lvl[i]}}) nlvl[i] = ~m_lvl[i];
    end
    pop = (m_q.size() > 0) && dir_ack;
    if (flush) begin
      m_q.delete();
      m_pend = '0;
    end else begin
      newp = m_pend;
      push = 1'b0;
      idx  = 0;
      if (newp != 0) begin
        for (int i = 3; i >= 0; i--) if (newp[i]) idx = i;
        newp[idx] = 1'b0;
        dup = (m_q.size() > 0) && (m_q[$] == idx);
        if (!dup) begin
          if (m_q.size() < DEPTH || pop) push = 1'b1;
          else m_ovf = 1'b1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(idx);
      m_pend = newp | rose;
    end
    m_lprev = m_lvl;
    m_lvl   = nlvl;
    m_s2    = m_s1;
    m_s1    = ~key_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_n = 4'hF; flush = 1'b0; dir_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic ack_pulse();
    dir_ack = 1'b1;
    tick();
    dir_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 4'h0; flush = 1'b0; dir_ack = 1'b1;
    repeat (3) tick();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dir_valid); end
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d want=0", dir); end
    total++; if (keys_held !== 4'h0) begin bad++; $display("FAIL reset_held got=%b want=0000", keys_held); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    key_n = 4'b1101;
    repeat (6) tick();
    total++; if (keys_held !== 4'b0000) begin bad++; $display("FAIL lat_held_e5 got=%b want=0000", keys_held); end
    tick();
    total++; if (keys_held !== 4'b0010) begin bad++; $display("FAIL lat_held_e6 got=%b want=0010", keys_held); end
    tick();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_e7 got=%b want=0", dir_valid); end
    tick();
    total++; if (dir_valid !== 1'b1 || dir !== 2'd1) begin bad++; $display("FAIL lat_valid_e8 got=%b/%0d want=1/1", dir_valid, dir); end
    repeat (10) tick();
    ack_pulse();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL lat_single got=%b want=0", dir_valid); end
  endtask

  task automatic test_bounce();
    do_reset();
    key_n = 4'b1110;
    repeat (3) tick();
    key_n = 4'hF;
    for (int c = 0; c < 15; c++) begin
      tick();
      total++;
      if (keys_held !== 4'h0 || dir_valid !== 1'b0) begin
        bad++; $display("FAIL bounce c=%0d got=%b/%b want=0000/0", c, keys_held, dir_valid);
      end
    end
  endtask

  task automatic fill_all();
    do_reset();
    key_n = 4'h0;
    repeat (14) tick();
    key_n = 4'hF;
    repeat (10) tick();
  endtask

  task automatic test_all_keys();
    fill_all();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL all_ovf got=%b want=0", overflow); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dir_valid !== 1'b1 || dir !== 2'(k)) begin
        bad++; $display("FAIL all_order k=%0d got=%b/%0d want=1/%0d", k, dir_valid, dir, k);
      end
      ack_pulse();
    end
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL all_empty got=%b want=0", dir_valid); end
  endtask

  task automatic test_overflow();
    int exp_a[4] = '{0, 1, 2, 3};
    int exp_b[4] = '{1, 2, 3, 0};
    fill_all();
    key_n = 4'b1110;
    repeat (14) tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dir_valid !== 1'b1 || dir !== 2'(exp_a[k])) begin
        bad++; $display("FAIL ovf_keep k=%0d got=%b/%0d want=1/%0d", k, dir_valid, dir, exp_a[k]);
      end
      ack_pulse();
    end
    fill_all();
    key_n = 4'b1110;
    for (int c = 0; c < 14; c++) begin
      dir_ack = (m_pend != 0);
      tick();
    end
    dir_ack = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pop got=%b want=0", overflow); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dir_valid !== 1'b1 || dir !== 2'(exp_b[k])) begin
        bad++; $display("FAIL ovf_rot k=%0d got=%b/%0d want=1/%0d", k, dir_valid, dir, exp_b[k]);
      end
      ack_pulse();
    end
  endtask

  task automatic test_dup();
    do_reset();
    key_n = 4'b1011; repeat (9) tick();
    key_n = 4'hF;    repeat (9) tick();
    key_n = 4'b1011; repeat (12) tick();
    total++; if (dir_valid !== 1'b1 || dir !== 2'd2) begin bad++; $display("FAIL dup_head got=%b/%0d want=1/2", dir_valid, dir); end
    ack_pulse();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL dup_single got=%b want=0", dir_valid); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    key_n = 4'b1100;
    repeat (12) tick();
    flush = 1'b1; dir_ack = 1'b1;
    tick();
    flush = 1'b0; dir_ack = 1'b0;
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", dir_valid); end
    total++; if (keys_held !== 4'b0011) begin bad++; $display("FAIL flush_held got=%b want=0011", keys_held); end
    key_n = 4'b1101;
    repeat (12) tick();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (dir_valid !== 1'b0 || dir !== 2'd0 || keys_held !== 4'h0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=%b/%0d/%b/%b want=0/0/0000/0", dir_valid, dir, keys_held, overflow);
    end
    rst = 1'b0;
    repeat (8) tick();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL rst_held_e7 got=%b want=0", dir_valid); end
    tick();
    total++; if (dir_valid !== 1'b1 || dir !== 2'd1) begin bad++; $display("FAIL rst_held_e8 got=%b/%0d want=1/1", dir_valid, dir); end
    repeat (8) tick();
    ack_pulse();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL rst_held_one got=%b want=0", dir_valid); end
  endtask

  task automatic test_random();
    int hold [4];
    do_reset();
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 14);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (--hold[i] <= 0) begin
          key_n[i] = ~key_n[i];
          hold[i]  = $urandom_range(1, 16);
        end
      end
      dir_ack = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 79) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
      total++;
      if (keys_held !== m_lvl || dir_valid !== (m_q.size() > 0) || overflow !== m_ovf ||
          (m_q.size() > 0 && dir !== 2'(m_q[0]))) begin
        bad++;
        $display("FAIL random c=%0d got=%b/%b/%0d/%b want=%b/%b/%0d/%b", c, keys_held, dir_valid, dir,
                 overflow, m_lvl, m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 0, m_ovf);
      end
    end
    rst = 1'b0; flush = 1'b0; dir_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_n = 4'hF; flush = 1'b0; dir_ack = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_all_keys();
    test_overflow();
    test_dup();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
